// File: rtl/rns_mac_accum_if.sv
// Handshake/bus bundle for rns_mac_accum: job start, product stream in,
// accumulated RNS result out. Optional bias inputs appear when the
// RNS_ACC_BIAS_EN macro is defined.
interface rns_mac_accum_if #(
   parameter int N     = 4,
   parameter int LEN_W = 8
);
   // Job control
   logic             start;
   logic [LEN_W-1:0] cfg_len;
   logic             busy;

   // Product beat stream
   logic             in_valid;
   logic             in_ready;
   logic [N:0]       p1;
   logic [N-1:0]     p2;
   logic [N-1:0]     p3;

   // Result handshake
   logic             out_valid;
   logic             out_ready;
   logic [N:0]       acc1;
   logic [N-1:0]     acc2;
   logic [N-1:0]     acc3;

`ifdef RNS_ACC_BIAS_EN
   // Per-channel bias, sampled with start
   logic [N:0]       b1;
   logic [N-1:0]     b2;
   logic [N-1:0]     b3;
`endif

   // Accumulator side
   modport slave (
      input  start, cfg_len, in_valid, p1, p2, p3, out_ready,
      output in_ready, out_valid, acc1, acc2, acc3, busy
`ifdef RNS_ACC_BIAS_EN
      , input b1, b2, b3
`endif
   );

   // Producer / consumer side
   modport master (
      output start, cfg_len, in_valid, p1, p2, p3, out_ready,
      input  in_ready, out_valid, acc1, acc2, acc3, busy
`ifdef RNS_ACC_BIAS_EN
      , output b1, b2, b3
`endif
   );
endinterface

// File: rtl/rns_mac_accum.sv
// rns_mac_accum: channel-wise modular accumulator for RNS products over the
// moduli set {2^(N+1)-1, 2^N, 2^N-1}. A job of cfg_len beats is summed and
// the result is offered through a valid/ready handshake.
// Optional feature: define RNS_ACC_BIAS_EN to seed the accumulators with a
// per-channel bias (b1/b2/b3) sampled together with start.
module rns_mac_accum #(
   parameter int N     = 4,
   parameter int LEN_W = 8
) (
   input logic            clk,
   input logic            rst_n,
   rns_mac_accum_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;

   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] cnt_reg;
   logic [N:0]       acc1_reg;
   logic [N-1:0]     acc2_reg;
   logic [N-1:0]     acc3_reg;

   logic             start_take;
   logic             xfer;
   logic             last_beat;
   logic [N:0]       init1;
   logic [N-1:0]     init2;
   logic [N-1:0]     init3;

   // End-around-carry add modulo 2^(N+1)-1. Either operand may be all-ones
   // (congruent to zero); the result is always canonical, never all-ones.
   function automatic logic [N:0] add_m1(input logic [N:0] a, input logic [N:0] b);
      logic [N+1:0] s;
      logic [N:0]   t;
      s = {1'b0, a} + {1'b0, b};
      t = s[N:0] + {{N{1'b0}}, s[N+1]};
      if (&t) begin
         t = '0;
      end
      return t;
   endfunction

   // End-around-carry add modulo 2^N-1, same canonical folding as add_m1.
   function automatic logic [N-1:0] add_m3(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N:0]   s;
      logic [N-1:0] t;
      s = {1'b0, a} + {1'b0, b};
      t = s[N-1:0] + {{(N-1){1'b0}}, s[N]};
      if (&t) begin
         t = '0;
      end
      return t;
   endfunction

   // Handshake qualifiers; start is only honoured in IDLE.
   assign start_take = (state_reg == IDLE) && bus.start;
   assign xfer       = (state_reg == ACCUM) && bus.in_valid;
   assign last_beat  = (cnt_reg == len_reg - LEN_W'(1));

`ifdef RNS_ACC_BIAS_EN
   // Seed values: bias folded into canonical range (all-ones means zero)
   assign init1 = (&bus.b1) ? '0 : bus.b1;
   assign init2 = bus.b2;
   assign init3 = (&bus.b3) ? '0 : bus.b3;
`else
   // Seed values: plain zero
   assign init1 = '0;
   assign init2 = '0;
   assign init3 = '0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next = (bus.cfg_len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (bus.in_valid && last_beat) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode from the state alone
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state_reg)
         ACCUM: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b1;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            bus.busy      = 1'b1;
         end
         default: begin
            bus.in_ready  = 1'b0;
            bus.out_valid = 1'b0;
            bus.busy      = 1'b0;
         end
      endcase
   end

   // Datapath: job setup on start, per-channel modular accumulate per beat.
   // The accumulators are untouched in DONE/IDLE so the result stays put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_reg  <= '0;
         cnt_reg  <= '0;
         acc1_reg <= '0;
         acc2_reg <= '0;
         acc3_reg <= '0;
      end else if (start_take) begin
         len_reg  <= bus.cfg_len;
         cnt_reg  <= '0;
         acc1_reg <= init1;
         acc2_reg <= init2;
         acc3_reg <= init3;
      end else if (xfer) begin
         cnt_reg  <= cnt_reg + LEN_W'(1);
         acc1_reg <= add_m1(acc1_reg, bus.p1);
         acc2_reg <= acc2_reg + bus.p2;
         acc3_reg <= add_m3(acc3_reg, bus.p3);
      end
   end

   assign bus.acc1 = acc1_reg;
   assign bus.acc2 = acc2_reg;
   assign bus.acc3 = acc3_reg;

endmodule

// File: tb/tb_rns_mac_accum.sv
// Directed, table-driven bench for rns_mac_accum (N=4: moduli 31/16/15).
module tb_rns_mac_accum;

   localparam int N     = 4;
   localparam int LEN_W = 8;

   logic clk;
   logic rst_n;

   rns_mac_accum_if #(.N(N), .LEN_W(LEN_W)) bus ();

   rns_mac_accum #(.N(N), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]      len;
      logic [2:0]      nb;
      logic            tog;
      logic [0:3][7:0] q1;
      logic [0:3][7:0] q2;
      logic [0:3][7:0] q3;
      logic [7:0]      e1;
      logic [7:0]      e2;
      logic [7:0]      e3;
   } vec_t;

   localparam int NVEC = 6;
   vec_t vecs [NVEC];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic vec_t mk(input int len, input int nb, input bit tog,
                               input logic [0:3][7:0] q1, input logic [0:3][7:0] q2,
                               input logic [0:3][7:0] q3,
                               input int e1, input int e2, input int e3);
      vec_t v;
      v.len = 8'(len);
      v.nb  = 3'(nb);
      v.tog = tog;
      v.q1  = q1;
      v.q2  = q2;
      v.q3  = q3;
      v.e1  = 8'(e1);
      v.e2  = 8'(e2);
      v.e3  = 8'(e3);
      return v;
   endfunction

   // Run one job from the table: start, beats, result check, handshake out
   task automatic run_vec(input int i, input vec_t v);
      bus.cfg_len = v.len;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
      for (int b = 0; b < int'(v.nb); b++) begin
         if (v.tog && b > 0) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_idle_ready", i), int'(bus.in_ready), 1);
            check($sformatf("v%0d_idle_valid", i), int'(bus.out_valid), 0);
         end
         check($sformatf("v%0d_b%0d_ready", i, b), int'(bus.in_ready), 1);
         bus.in_valid = 1'b1;
         bus.p1       = v.q1[b][4:0];
         bus.p2       = v.q2[b][3:0];
         bus.p3       = v.q3[b][3:0];
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      check($sformatf("v%0d_out_valid", i), int'(bus.out_valid), 1);
      check($sformatf("v%0d_in_ready", i), int'(bus.in_ready), 0);
      check($sformatf("v%0d_acc1", i), int'(bus.acc1), int'(v.e1));
      check($sformatf("v%0d_acc2", i), int'(bus.acc2), int'(v.e2));
      check($sformatf("v%0d_acc3", i), int'(bus.acc3), int'(v.e3));
      $display("vec %0d len=%0d acc=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
               i, v.len, bus.acc1, bus.acc2, bus.acc3, v.e1, v.e2, v.e3);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check($sformatf("v%0d_release_valid", i), int'(bus.out_valid), 0);
      check($sformatf("v%0d_release_busy", i), int'(bus.busy), 0);
   endtask

   initial begin
      vecs[0] = mk(3, 3, 1'b0, {8'd30, 8'd30, 8'd30, 8'd0}, {8'd15, 8'd15, 8'd15, 8'd0},
                   {8'd14, 8'd14, 8'd14, 8'd0}, 28, 13, 12);
      vecs[1] = mk(2, 2, 1'b0, {8'd31, 8'd5, 8'd0, 8'd0}, {8'd0, 8'd3, 8'd0, 8'd0},
                   {8'd15, 8'd7, 8'd0, 8'd0}, 5, 3, 7);
      vecs[2] = mk(2, 2, 1'b0, {8'd16, 8'd15, 8'd0, 8'd0}, {8'd8, 8'd8, 8'd0, 8'd0},
                   {8'd8, 8'd7, 8'd0, 8'd0}, 0, 0, 0);
      vecs[3] = mk(0, 0, 1'b0, '0, '0, '0, 0, 0, 0);
      vecs[4] = mk(4, 4, 1'b1, {8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1},
                   {8'd1, 8'd1, 8'd1, 8'd1}, 4, 4, 4);
      vecs[5] = mk(2, 2, 1'b0, {8'd30, 8'd30, 8'd0, 8'd0}, {8'd15, 8'd15, 8'd0, 8'd0},
                   {8'd14, 8'd14, 8'd0, 8'd0}, 29, 14, 13);

      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.cfg_len   = '0;
      bus.in_valid  = 1'b0;
      bus.p1        = '0;
      bus.p2        = '0;
      bus.p3        = '0;
      bus.out_ready = 1'b0;
`ifdef RNS_ACC_BIAS_EN
      bus.b1        = '0;
      bus.b2        = '0;
      bus.b3        = '0;
`endif

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_in_ready", int'(bus.in_ready), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_acc1", int'(bus.acc1), 0);
      check("rst_acc2", int'(bus.acc2), 0);
      check("rst_acc3", int'(bus.acc3), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NVEC; i++) begin
         run_vec(i, vecs[i]);
      end

      // Result held with out_ready low while start keeps pulsing
      bus.cfg_len = 8'd1;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.p1       = 5'd7;
      bus.p2       = 4'd7;
      bus.p3       = 4'd7;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.start   = 1'b1;
         bus.cfg_len = (k % 2 == 0) ? 8'd0 : 8'd2;
         @(negedge clk);
         check($sformatf("hold%0d_valid", k), int'(bus.out_valid), 1);
         check($sformatf("hold%0d_in_ready", k), int'(bus.in_ready), 0);
         check($sformatf("hold%0d_acc1", k), int'(bus.acc1), 7);
         check($sformatf("hold%0d_acc3", k), int'(bus.acc3), 7);
         $display("hold cycle %0d out_valid=%0d acc=(%0d,%0d,%0d)",
                  k, bus.out_valid, bus.acc1, bus.acc2, bus.acc3);
      end
      // Handshake with start asserted in the same cycle: start must be ignored
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      bus.cfg_len   = 8'd0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      check("hold_release_busy", int'(bus.busy), 0);
      check("hold_release_valid", int'(bus.out_valid), 0);
      @(negedge clk);
      check("hold_idle_busy", int'(bus.busy), 0);
      check("hold_idle_acc2", int'(bus.acc2), 7);
      $display("hold released busy=%0d acc=(%0d,%0d,%0d)", bus.busy, bus.acc1, bus.acc2, bus.acc3);

      // Reset in the middle of a five-beat job
      bus.cfg_len = 8'd5;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.p1       = 5'd3;
      bus.p2       = 4'd3;
      bus.p3       = 4'd3;
      @(negedge clk);
      @(negedge clk);
      check("mid_acc1", int'(bus.acc1), 6);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", int'(bus.busy), 0);
      check("mid_rst_in_ready", int'(bus.in_ready), 0);
      check("mid_rst_out_valid", int'(bus.out_valid), 0);
      check("mid_rst_acc1", int'(bus.acc1), 0);
      check("mid_rst_acc2", int'(bus.acc2), 0);
      check("mid_rst_acc3", int'(bus.acc3), 0);
      $display("mid-job reset busy=%0d acc=(%0d,%0d,%0d)", bus.busy, bus.acc1, bus.acc2, bus.acc3);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", int'(bus.busy), 0);
      bus.cfg_len = 8'd1;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      check("post_rst_ready", int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.p1       = 5'd3;
      bus.p2       = 4'd2;
      bus.p3       = 4'd1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("post_rst_valid", int'(bus.out_valid), 1);
      check("post_rst_acc1", int'(bus.acc1), 3);
      check("post_rst_acc2", int'(bus.acc2), 2);
      check("post_rst_acc3", int'(bus.acc3), 1);
      $display("post-reset job acc=(%0d,%0d,%0d)", bus.acc1, bus.acc2, bus.acc3);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("post_rst_release_busy", int'(bus.busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rns_mac_accum.md
Name: rns_mac_accum

Overview:
- Downstream consumer of the three-channel RNS multiplier for moduli set {2^(N+1)-1, 2^N, 2^N-1}.
- Accumulates a configurable-length stream of RNS products channel-wise, with a modular add per channel, to form a dot product for one DNN neuron.
- Presents the result through a valid/ready output handshake, for a reverse converter or the next layer.

Parameters:
- N, 4, base width. Channel 1 is N+1 bits (mod 2^(N+1)-1), channel 2 is N bits (mod 2^N), channel 3 is N bits (mod 2^N-1).
- LEN_W, 8, width of the dot-product length field.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a new accumulation. Honoured only in IDLE.
- cfg_len  in  LEN_W  number of products to accumulate. Sampled when start is honoured.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block accepts a product beat.
- p1  in  N+1  product residue, modulus 2^(N+1)-1.
- p2  in  N  product residue, modulus 2^N.
- p3  in  N  product residue, modulus 2^N-1.
- out_valid  out  1  accumulated result valid.
- out_ready  in  1  downstream accepts the result.
- acc1  out  N+1  result residue, modulus 2^(N+1)-1.
- acc2  out  N  result residue, modulus 2^N.
- acc3  out  N  result residue, modulus 2^N-1.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - acc1, acc2, acc3 = 0.
  - Beat counter = 0.
  - in_ready = 0, out_valid = 0, busy = 0.
- States: IDLE, ACCUM, DONE.
- IDLE, on start=1:
  - Clear accumulators and counter.
  - Latch cfg_len.
  - If cfg_len != 0, go to ACCUM. If cfg_len == 0, go to DONE with the zero result.
- ACCUM:
  - in_ready = 1.
  - A beat transfers when in_valid & in_ready.
  - On each transfer, per channel:
    - acc1 = (acc1 + p1) mod (2^(N+1)-1), using an end-around-carry adder.
    - acc2 = (acc2 + p2) mod 2^N, discarding the carry.
    - acc3 = (acc3 + p3) mod (2^N-1), using an end-around-carry adder.
  - The counter increments on each transfer.
  - On the transfer where counter == len-1, go to DONE.
  - in_valid low inserts idle cycles; accumulators and counter hold.
- DONE:
  - out_valid = 1.
  - acc* are registered outputs and remain stable while out_valid=1 and out_ready=0.
  - in_ready = 0.
  - On out_valid & out_ready, go to IDLE and deassert out_valid the next cycle. The acc* values remain until the next start.
- Latency: out_valid rises the cycle after the final accepted beat, or the cycle after start when cfg_len=0.
- Canonical form:
  - Inputs equal to all-ones on channels 1 and 3 (11111 / 1111 for N=4) are congruent to zero and accepted as such.
  - acc1 and acc3 are always in [0, m-1] and never all-ones. An all-ones sum folds to 0.
- Simultaneous events:
  - start is ignored outside IDLE.
  - start in the same cycle as an IDLE-bound out handshake is ignored; it must be re-issued once IDLE.
- Reset mid-operation: any state returns to IDLE immediately; a partial sum is discarded.
- Length limit: cfg_len is interpreted as unsigned up to 2^LEN_W-1. The counter never wraps within one job.

Optional Feature:
- Macro RNS_ACC_BIAS_EN.
- Defined:
  - Adds inputs b1 (N+1 bits), b2 (N bits) and b3 (N bits), sampled with start.
  - The accumulators initialise to the canonicalised bias instead of 0.
  - With cfg_len=0 the result equals the bias.
- Undefined:
  - The ports are absent and the accumulators initialise to 0.

Test Plan:
- N=4 (moduli 31/16/15), cfg_len=3, three beats of (30,15,14), in_valid continuous -> result (28,13,12); out_valid rises the cycle after the 3rd beat.
- cfg_len=2, beats (31,0,15) then (5,3,7) -> result (5,3,7). Also beats (16,8,8) then (15,8,7) -> result (0,0,0), never all-ones.
- cfg_len=0, start -> out_valid next cycle with (0,0,0); in_ready never asserted.
- cfg_len=4, in_valid toggling 1/0 each cycle, beats (1,1,1) -> result (4,4,4) after 4 accepted beats; the counter ignores idle cycles.
- Result pending with out_ready=0 for 5 cycles while start pulses -> acc* stable, in_ready=0, start ignored; out_ready=1 -> IDLE, busy=0.
- rst_n pulsed low after 2 of 5 beats -> immediately IDLE with acc*=0 and flags 0. A new start with cfg_len=1 and beat (3,2,1) -> result (3,2,1).
